// File: rtl/regs_mp_pkg.sv
// Shared defaults, zero constants and debug FSM encodings for the regs_mp register file.
package regs_mp_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;
  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_ACC  = 2'd1,
    DBG_RESP = 2'd2
  } dbg_state_e;
endpackage

// File: rtl/regs_dbg_arb.sv
// Debug access arbiter: waits for a cycle free of core writes, grants, then
// returns one response beat. Core writes always win, so a debug write can
// never collide with a core write in the same cycle.
module regs_dbg_arb
  import regs_mp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            core_wr,
  input  logic            wr_ok,
  input  logic [XLEN-1:0] rd_val,
  output logic            gnt,
  output logic            rvalid,
  output logic [XLEN-1:0] rdata,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [AW-1:0]   rd_addr
);
  dbg_state_e state, state_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DBG_IDLE;
    else     state <= state_nxt;
  end

  // Next state and grant; grant is gated by rst so a reset in ACC never grants.
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    case (state)
      DBG_IDLE: if (req) state_nxt = DBG_ACC;
      DBG_ACC: begin
        if (!core_wr && !rst) begin
          gnt       = 1'b1;
          state_nxt = DBG_RESP;
        end
      end
      DBG_RESP: state_nxt = DBG_IDLE;
      default:  state_nxt = DBG_IDLE;
    endcase
  end

  // Response beat follows the grant; writes echo the value actually stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= XLEN'(ZERO_WORD);
    end else begin
      rvalid <= gnt;
      if (gnt) rdata <= we ? (wr_ok ? wdata : XLEN'(ZERO_WORD)) : rd_val;
    end
  end

  assign wr_en   = gnt & we;
  assign wr_addr = addr;
  assign wr_data = wdata;
  assign rd_addr = addr;
endmodule

// File: rtl/regs_mp.sv
// Multi-port integer register file: NRD bypassed combinational reads, two
// write ports (ex and long-latency writeback), busy scoreboard, debug port.
module regs_mp
  import regs_mp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wa_we_i,
  input  logic [AW-1:0]       wa_addr_i,
  input  logic [XLEN-1:0]     wa_data_i,
  input  logic                wb_we_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic [NREG-1:0]     busy_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [AW-1:0]       dbg_addr_i,
  input  logic [XLEN-1:0]     dbg_wdata_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [XLEN-1:0]     dbg_rdata_o
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;

  logic            dbg_wr_en;
  logic [AW-1:0]   dbg_wr_addr;
  logic [XLEN-1:0] dbg_wr_data;
  logic [AW-1:0]   dbg_rd_addr;
  logic [XLEN-1:0] dbg_rd_val;
  logic            dbg_wr_ok;

  // Address maps to real storage: in range and not the hardwired zero register.
  function automatic logic live(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREG)) && !((ZERO_R0 != 0) && (a == AW'(ZERO_REG)));
  endfunction

  // Storage update: A beats B on the same address; debug only lands when both are idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int n = 0; n < NREG; n++) begin
        if (wa_we_i && wa_addr_i == AW'(n) && live(wa_addr_i))
          regs[n] <= wa_data_i;
        else if (wb_we_i && wb_addr_i == AW'(n) && live(wb_addr_i))
          regs[n] <= wb_data_i;
        else if (dbg_wr_en && dbg_wr_addr == AW'(n) && live(dbg_wr_addr))
          regs[n] <= dbg_wr_data;
      end
    end
  end

  // Scoreboard: issue sets, writeback clears, set wins on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int n = 0; n < NREG; n++) begin
        if (sb_set_i && sb_addr_i == AW'(n) && n != ZERO_REG)
          busy[n] <= 1'b1;
        else if (wb_we_i && wb_addr_i == AW'(n))
          busy[n] <= 1'b0;
      end
    end
  end

  assign busy_o = busy;

  // Read ports, one per lane, with write-through bypass from both write ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbusy;

    assign ra = rd_addr_i[k*AW +: AW];

    // Priority: zero/out-of-range, port A bypass, port B bypass, storage.
    always_comb begin
      rdat  = XLEN'(ZERO_WORD);
      rbusy = 1'b0;
      if (live(ra)) begin
        if (wa_we_i && wa_addr_i == ra)      rdat = wa_data_i;
        else if (wb_we_i && wb_addr_i == ra) rdat = wb_data_i;
        else                                 rdat = regs[ra];
        rbusy = busy[ra] & ~(wb_we_i && wb_addr_i == ra);
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = rdat;
    assign rd_busy_o[k]              = rbusy;
  end

  assign dbg_rd_val = live(dbg_rd_addr) ? regs[dbg_rd_addr] : XLEN'(ZERO_WORD);
  assign dbg_wr_ok  = live(dbg_addr_i);

  regs_dbg_arb #(.XLEN(XLEN), .AW(AW)) u_dbg (
    .clk     (clk),
    .rst     (rst),
    .req     (dbg_req_i),
    .we      (dbg_we_i),
    .addr    (dbg_addr_i),
    .wdata   (dbg_wdata_i),
    .core_wr (wa_we_i | wb_we_i),
    .wr_ok   (dbg_wr_ok),
    .rd_val  (dbg_rd_val),
    .gnt     (dbg_gnt_o),
    .rvalid  (dbg_rvalid_o),
    .rdata   (dbg_rdata_o),
    .wr_en   (dbg_wr_en),
    .wr_addr (dbg_wr_addr),
    .wr_data (dbg_wr_data),
    .rd_addr (dbg_rd_addr)
  );
endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp: default 32-entry instance plus a 24-entry instance.
module tb_regs_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        wa_we, wb_we, sb_set, dbg_req, dbg_we;
  logic [4:0]  wa_addr, wb_addr, sb_addr, dbg_addr, ra0, ra1;
  logic [31:0] wa_data, wb_data, dbg_wdata;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [31:0] busy;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        v_wa_we, v_sb_set;
  logic [4:0]  v_wa_addr, v_sb_addr, v_ra;
  logic [31:0] v_wa_data;
  logic [63:0] v_rd_data;
  logic [1:0]  v_rd_busy;
  logic [23:0] v_busy;
  logic        v_gnt, v_rvalid;
  logic [31:0] v_rdata;

  int n_chk = 0;
  int n_fail = 0;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  regs_mp u0 (
    .clk(clk), .rst(rst),
    .wa_we_i(wa_we), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy), .busy_o(busy),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(gnt), .dbg_rvalid_o(rvalid), .dbg_rdata_o(rdata)
  );

  regs_mp #(.NREG(24)) u1 (
    .clk(clk), .rst(rst),
    .wa_we_i(v_wa_we), .wa_addr_i(v_wa_addr), .wa_data_i(v_wa_data),
    .wb_we_i(1'b0), .wb_addr_i(5'd0), .wb_data_i(32'd0),
    .sb_set_i(v_sb_set), .sb_addr_i(v_sb_addr),
    .rd_addr_i({v_ra, v_ra}), .rd_data_o(v_rd_data), .rd_busy_o(v_rd_busy), .busy_o(v_busy),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(5'd0), .dbg_wdata_i(32'd0),
    .dbg_gnt_o(v_gnt), .dbg_rvalid_o(v_rvalid), .dbg_rdata_o(v_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    wa_we = 0; wa_addr = 0; wa_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    sb_set = 0; sb_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; core_idle(); ra0 = 0; ra1 = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    v_wa_we = 0; v_wa_addr = 0; v_wa_data = 0; v_sb_set = 0; v_sb_addr = 0; v_ra = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {31'd0, gnt}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);

    // Port A write with same-cycle bypass, then storage read
    tick(); wa_we = 1; wa_addr = 5; wa_data = 32'h1234_5678; ra1 = 5; ra0 = 6;
    @(negedge clk); chk("bypass_a_r5", rd_data[63:32], 32'h1234_5678);
    chk("r6_untouched", rd_data[31:0], 0);
    tick(); core_idle(); ra0 = 5;
    @(negedge clk); chk("stored_r5", rd_data[31:0], 32'h1234_5678);

    // A/B collision on r7 with r7 busy
    tick(); sb_set = 1; sb_addr = 7;
    tick(); core_idle(); ra0 = 7;
    @(negedge clk); chk("busy7_set", {31'd0, busy[7]}, 1);
    tick(); wa_we = 1; wa_addr = 7; wa_data = 32'hAAAA_AAAA;
    wb_we = 1; wb_addr = 7; wb_data = 32'hBBBB_BBBB;
    @(negedge clk); chk("bypass_a_over_b", rd_data[31:0], 32'hAAAA_AAAA);
    tick(); core_idle();
    @(negedge clk); chk("r7_a_wins", rd_data[31:0], 32'hAAAA_AAAA);
    chk("busy7_cleared", {31'd0, busy[7]}, 0);

    // Scoreboard on r3
    tick(); sb_set = 1; sb_addr = 3; ra0 = 3;
    tick(); core_idle();
    @(negedge clk); chk("rd_busy_r3", {30'd0, rd_busy}, 32'd1);
    tick(); wb_we = 1; wb_addr = 3; wb_data = 32'h55;
    @(negedge clk); chk("rd_busy_wb_cyc", {30'd0, rd_busy}, 0);
    chk("bypass_b_r3", rd_data[31:0], 32'h55);
    tick(); core_idle();
    @(negedge clk); chk("busy3_clr", {31'd0, busy[3]}, 0);
    tick(); sb_set = 1; sb_addr = 3; wb_we = 1; wb_addr = 3; wb_data = 32'h66;
    tick(); core_idle();
    @(negedge clk); chk("busy3_set_wins", {31'd0, busy[3]}, 1);
    chk("r3_b_data", rd_data[31:0], 32'h66);

    // Debug write r9 stalled 3 cycles by port A
    tick(); dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("dbg_idle_nognt", {31'd0, gnt}, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); wa_we = 1; wa_addr = 10; wa_data = 32'(i);
      @(negedge clk); chk("dbg_stall", {31'd0, gnt}, 0);
    end
    tick(); core_idle();
    @(negedge clk); chk("dbg_gnt", {31'd0, gnt}, 1);
    tick(); dbg_req = 0; dbg_we = 0;
    @(negedge clk); chk("dbg_rvalid", {31'd0, rvalid}, 1);
    chk("dbg_wr_echo", rdata, 32'hDEAD_BEEF);
    chk("dbg_gnt_pulse", {31'd0, gnt}, 0);
    tick(); ra0 = 9;
    @(negedge clk); chk("dbg_rvalid_pulse", {31'd0, rvalid}, 0);
    chk("r9_dbg_written", rd_data[31:0], 32'hDEAD_BEEF);

    // Reset while the debug FSM sits in ACC
    tick(); dbg_req = 1; dbg_we = 0; dbg_addr = 9;
    tick(); rst = 1;
    @(negedge clk); chk("rst_acc_nognt", {31'd0, gnt}, 0);
    tick(); rst = 0; dbg_req = 0; ra0 = 5;
    @(negedge clk); chk("post_rst_gnt", {31'd0, gnt}, 0);
    chk("post_rst_rvalid", {31'd0, rvalid}, 0);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_r5", rd_data[31:0], 0);
    tick();
    @(negedge clk); chk("post_rst_no_resp", {31'd0, rvalid}, 0);

    // New debug write after reset completes in best-case time
    tick(); dbg_req = 1; dbg_we = 1; dbg_addr = 4; dbg_wdata = 32'h77;
    tick();
    @(negedge clk); chk("dbg2_gnt", {31'd0, gnt}, 1);
    tick(); dbg_req = 0; dbg_we = 0;
    @(negedge clk); chk("dbg2_rvalid", {31'd0, rvalid}, 1);
    chk("dbg2_rdata", rdata, 32'h77);
    tick(); ra0 = 4;
    @(negedge clk); chk("r4_dbg_written", rd_data[31:0], 32'h77);

    // r0 is hardwired zero on every write path
    tick(); wa_we = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF; sb_set = 1; sb_addr = 0; ra0 = 0;
    @(negedge clk); chk("r0_no_bypass_a", rd_data[31:0], 0);
    tick(); core_idle(); wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
    @(negedge clk); chk("r0_no_bypass_b", rd_data[31:0], 0);
    tick(); core_idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hABCD;
    tick();
    @(negedge clk); chk("dbg_r0_gnt", {31'd0, gnt}, 1);
    tick(); dbg_req = 0; dbg_we = 0;
    @(negedge clk); chk("dbg_r0_wr_resp", rdata, 0);
    chk("r0_stays_zero", rd_data[31:0], 0);
    chk("busy0_zero", {31'd0, busy[0]}, 0);

    // Debug reads: r4 then r0
    tick(); tick(); dbg_req = 1; dbg_addr = 4;
    tick(); tick(); dbg_req = 0;
    @(negedge clk); chk("dbg_rd_r4", rdata, 32'h77);
    tick(); tick(); dbg_req = 1; dbg_addr = 0;
    tick(); tick(); dbg_req = 0;
    @(negedge clk); chk("dbg_rd_r0_valid", {31'd0, rvalid}, 1);
    chk("dbg_rd_r0", rdata, 0);

    // NREG=24: out-of-range address is dead, top entry works
    tick(); v_wa_we = 1; v_wa_addr = 30; v_wa_data = 32'hCAFE; v_sb_set = 1; v_sb_addr = 30; v_ra = 30;
    @(negedge clk); chk("n24_r30_bypass", v_rd_data[31:0], 0);
    tick(); v_wa_addr = 23; v_wa_data = 32'h23; v_sb_set = 0; v_ra = 23;
    @(negedge clk); chk("n24_r23_bypass", v_rd_data[31:0], 32'h23);
    tick(); v_wa_we = 0; v_ra = 30;
    @(negedge clk); chk("n24_r30_read", v_rd_data[31:0], 0);
    chk("n24_busy", {8'd0, v_busy}, 0);
    tick(); v_ra = 23;
    @(negedge clk); chk("n24_r23_stored", v_rd_data[63:32], 32'h23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
